// File: rtl/fuzzy_host_pkg.sv
// fuzzy_host_pkg
// Shared types and constants for the fuzzy host sequencer.
//   state_e  : sequencer FSM states
//   result_t : one buffered result {g, lat, timeout}
//   G_MAX    : largest legal percentage returned by the coprocessor
//   clamp_g  : saturates a raw coprocessor result to G_MAX
package fuzzy_host_pkg;

    localparam int G_MAX           = 100;
    localparam int TIMEOUT_DEFAULT = 32;
    localparam int LAT_W           = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT_P  = 3'd1,
        ST_START_P = 3'd2,
        ST_WAIT    = 3'd3,
        ST_PUSH    = 3'd4
    } state_e;

    typedef struct packed {
        logic [7:0]       g;
        logic [LAT_W-1:0] lat;
        logic             timeout;
    } result_t;

    function automatic logic [7:0] clamp_g(input logic [7:0] g);
        return (g > 8'(G_MAX)) ? 8'(G_MAX) : g;
    endfunction

endpackage

// File: rtl/fuzzy_host_sequencer_result_fifo.sv
// result_fifo
// Synchronous first-word-fall-through FIFO for sequencer results.
// The head entry is visible on data_o whenever empty_o is low.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties FIFO)
//   push_i, data_i  : write request and data
//   pop_i, data_o   : read request and head data
//   empty_o, full_o : fill status
// DEPTH must be a power of two, at least 2, so the pointers wrap for free.
module result_fifo
    import fuzzy_host_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // accepted when it is paired with a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fuzzy_host_sequencer.sv
// fuzzy_host_sequencer
// Accepts {T, dT} samples, drives them to a fuzzy coprocessor with optional
// init and start pulses, waits (bounded by TIMEOUT) for the result strobe,
// and buffers {G, latency, timeout} results in an FWFT FIFO.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; ready never depends on valid.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   s_valid/s_ready, s_T, s_dT  : sample input, s_init requests a cp_init pulse
//   cp_start, cp_init           : one-cycle registered coprocessor pulses
//   cp_T_in, cp_dT_in           : operands, held until the next sample
//   cp_valid, cp_G              : coprocessor result strobe and value
//   r_valid/r_ready, r_G, r_lat, r_timeout : result output (FIFO head)
//   busy                        : FSM not idle
//   err_spurious, err_range     : sticky error flags
//   dbg_state                   : current FSM state
module fuzzy_host_sequencer
    import fuzzy_host_pkg::*;
#(
    parameter int TIMEOUT    = TIMEOUT_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_T,
    input  logic [7:0] s_dT,
    input  logic       s_init,
    output logic       cp_start,
    output logic       cp_init,
    output logic [7:0] cp_T_in,
    output logic [7:0] cp_dT_in,
    input  logic       cp_valid,
    input  logic [7:0] cp_G,
    output logic       r_valid,
    input  logic       r_ready,
    output logic [7:0] r_G,
    output logic [5:0] r_lat,
    output logic       r_timeout,
    output logic       busy,
    output logic       err_spurious,
    output logic       err_range,
    output logic [2:0] dbg_state
);

    localparam logic [LAT_W-1:0] TMO = LAT_W'(TIMEOUT);

    state_e           state_q;
    logic             ready_en_q;
    logic             cp_start_q;
    logic             cp_init_q;
    logic [7:0]       cp_T_q;
    logic [7:0]       cp_dT_q;
    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] elapsed;
    result_t          res_q;
    logic             err_spur_q;
    logic             err_range_q;
    logic             hs;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    result_t          fifo_dout;

    // ready_en_q holds s_ready low until the first edge after reset release.
    assign s_ready   = ready_en_q & (state_q == ST_IDLE) & ~fifo_full;
    assign hs        = s_valid & s_ready;
    // Cycles since the cp_start cycle, as seen in the current WAIT cycle.
    assign elapsed   = cnt_q + LAT_W'(1);

    assign fifo_push = (state_q == ST_PUSH);
    assign fifo_pop  = r_valid & r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ready_en_q  <= 1'b0;
            cp_start_q  <= 1'b0;
            cp_init_q   <= 1'b0;
            cp_T_q      <= '0;
            cp_dT_q     <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            err_spur_q  <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            cp_start_q <= 1'b0;
            cp_init_q  <= 1'b0;
            if (cp_valid && state_q != ST_WAIT) begin
                err_spur_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        cp_T_q  <= s_T;
                        cp_dT_q <= s_dT;
                        if (s_init) begin
                            state_q   <= ST_INIT_P;
                            cp_init_q <= 1'b1;
                        end else begin
                            state_q    <= ST_START_P;
                            cp_start_q <= 1'b1;
                        end
                    end
                end
                ST_INIT_P: begin
                    state_q    <= ST_START_P;
                    cp_start_q <= 1'b1;
                end
                ST_START_P: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= '0;
                end
                ST_WAIT: begin
                    cnt_q <= elapsed;
                    // A strobe arriving on the timeout cycle still counts.
                    if (cp_valid) begin
                        res_q.g       <= clamp_g(cp_G);
                        res_q.lat     <= elapsed;
                        res_q.timeout <= 1'b0;
                        if (cp_G > 8'(G_MAX)) begin
                            err_range_q <= 1'b1;
                        end
                        state_q <= ST_PUSH;
                    end else if (elapsed == TMO) begin
                        res_q.g       <= '0;
                        res_q.lat     <= TMO;
                        res_q.timeout <= 1'b1;
                        state_q       <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (result_t)
    ) u_result_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (res_q),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign cp_start     = cp_start_q;
    assign cp_init      = cp_init_q;
    assign cp_T_in      = cp_T_q;
    assign cp_dT_in     = cp_dT_q;
    assign r_valid      = ~fifo_empty;
    assign r_G          = fifo_dout.g;
    assign r_lat        = fifo_dout.lat;
    assign r_timeout    = fifo_dout.timeout;
    assign busy         = (state_q != ST_IDLE);
    assign err_spurious = err_spur_q;
    assign err_range    = err_range_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fuzzy_host_sequencer.sv
// Self-checking bench for fuzzy_host_sequencer: table of directed samples,
// hand-written multi-cycle sequences, and a randomized run scored against a
// result model derived from the sequencer's rules.
module tb_fuzzy_host_sequencer;
    import fuzzy_host_pkg::*;

    localparam int TMO = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s_valid, s_ready, s_init;
    logic [7:0] s_T, s_dT;
    logic       cp_start, cp_init, cp_valid;
    logic [7:0] cp_T_in, cp_dT_in, cp_G;
    logic       r_valid, r_ready, r_timeout;
    logic [7:0] r_G;
    logic [5:0] r_lat;
    logic       busy, err_spurious, err_range;
    logic [2:0] dbg_state;

    fuzzy_host_sequencer #(.TIMEOUT(TMO), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_T(s_T), .s_dT(s_dT), .s_init(s_init),
        .cp_start(cp_start), .cp_init(cp_init), .cp_T_in(cp_T_in), .cp_dT_in(cp_dT_in),
        .cp_valid(cp_valid), .cp_G(cp_G),
        .r_valid(r_valid), .r_ready(r_ready), .r_G(r_G), .r_lat(r_lat), .r_timeout(r_timeout),
        .busy(busy), .err_spurious(err_spurious), .err_range(err_range), .dbg_state(dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({s_ready, cp_start, cp_init, cp_T_in, cp_dT_in, r_valid, r_G, r_lat,
                    r_timeout, busy, err_spurious, err_range});
    endfunction

    // ---------------- coprocessor model ----------------
    int         cop_lat    = 7;
    logic [7:0] cop_g      = 8'd0;
    bit         cop_silent = 1'b0;
    int         cd         = 0;
    int         start_cnt  = 0;
    logic       cop_valid  = 1'b0;
    logic       force_valid = 1'b0;

    assign cp_valid = cop_valid | force_valid;
    assign cp_G     = cop_g;

    // Strobe cp_valid exactly cop_lat cycles after the cycle cp_start is high.
    always @(posedge clk) begin
        #1;
        cop_valid = 1'b0;
        if (rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) cop_valid = 1'b1;
            end
            if (cp_start) begin
                start_cnt++;
                if (!cop_silent) cd = cop_lat;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [14:0] exp_q[$];
    bit mon_en     = 1'b0;
    bit rnd_ready  = 1'b0;

    function automatic logic [14:0] model(input logic [7:0] g, input int lat, input bit sil);
        if (sil || lat > TMO) return {8'd0, 6'(TMO), 1'b1};
        return {(g > 8'd100) ? 8'd100 : g, 6'(lat), 1'b0};
    endfunction

    always @(negedge clk) begin
        if (mon_en && r_valid && r_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'({r_G, r_lat, r_timeout}), 64'd0);
            end else begin
                check("rand_result", 64'({r_G, r_lat, r_timeout}), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        if (rnd_ready) r_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] dt, input logic ini, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        s_T = t; s_dT = dt; s_init = ini; s_valid = 1'b1;
        while (!ok && n < 200) begin
            if (s_ready) ok = 1'b1;
            tick();
            n++;
        end
        s_valid = 1'b0;
        s_init  = 1'b0;
        check("handshake", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!r_valid && n < 200) begin tick(); n++; end
        check("result_arrives", 64'(r_valid), 64'd1);
    endtask

    task automatic pop();
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] t;
        logic [7:0] dt;
        logic       init;
        int         lat;
        logic [7:0] g;
        bit         silent;
        logic [7:0] exp_g;
        logic [5:0] exp_lat;
        logic       exp_to;
        logic       exp_rng;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=expired required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        bit         stable;
        int         n;
        int         s0;
        logic [7:0] rt, rdt, rg;
        int         rlat;
        bit         rsil, rini;

        vecs[0] = '{8'h00, 8'h00, 1'b0,  7, 8'd42,  1'b0, 8'd42,  6'd7,  1'b0, 1'b0};
        vecs[1] = '{8'hFB, 8'h0C, 1'b1,  3, 8'd100, 1'b0, 8'd100, 6'd3,  1'b0, 1'b0};
        vecs[2] = '{8'h10, 8'hF0, 1'b0, 32, 8'd77,  1'b0, 8'd77,  6'd32, 1'b0, 1'b0};
        vecs[3] = '{8'h01, 8'h02, 1'b0,  0, 8'd55,  1'b1, 8'd0,   6'd32, 1'b1, 1'b0};
        vecs[4] = '{8'h64, 8'h64, 1'b0,  1, 8'd150, 1'b0, 8'd100, 6'd1,  1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'h7F, 1'b1,  5, 8'd101, 1'b0, 8'd100, 6'd5,  1'b0, 1'b1};
        vecs[6] = '{8'h07, 8'h07, 1'b0,  2, 8'd0,   1'b0, 8'd0,   6'd2,  1'b0, 1'b1};

        s_valid = 1'b0; s_T = '0; s_dT = '0; s_init = 1'b0; r_ready = 1'b0;

        // Reset: outputs zero while asserted, s_ready waits for a clock edge.
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_outputs_zero", out_vec(), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("ready_low_before_edge", 64'(s_ready), 64'd0);
        tick();
        check("ready_after_edge", 64'(s_ready), 64'd1);
        check("idle_not_busy", 64'(busy), 64'd0);

        // Init pulse followed by start pulse, operands held through the strobe.
        cop_lat = 4; cop_g = 8'd60; cop_silent = 1'b0;
        s_T = 8'd16; s_dT = 8'd3; s_init = 1'b1; s_valid = 1'b1;
        check("init_seq_ready", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0; s_init = 1'b0;
        check("init_pulse", 64'({cp_init, cp_start}), 64'b10);
        tick();
        check("start_after_init", 64'({cp_init, cp_start}), 64'b01);
        tick();
        check("start_one_cycle", 64'({cp_init, cp_start}), 64'b00);
        n = 0; stable = 1'b1;
        while (!cp_valid && n < 50) begin
            if (cp_T_in !== 8'd16 || cp_start !== 1'b0) stable = 1'b0;
            tick();
            n++;
        end
        check("t_stable_through_valid", 64'({stable, cp_T_in}), 64'({1'b1, 8'd16}));
        wait_result();
        check("init_seq_lat", 64'({r_G, r_lat, r_timeout}), 64'({8'd60, 6'd4, 1'b0}));
        pop();

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            cop_lat = vecs[i].lat; cop_g = vecs[i].g; cop_silent = vecs[i].silent;
            s0 = start_cnt;
            send(vecs[i].t, vecs[i].dt, vecs[i].init, ok);
            wait_result();
            check($sformatf("v%0d_r_G", i), 64'(r_G), 64'(vecs[i].exp_g));
            check($sformatf("v%0d_r_lat", i), 64'(r_lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_r_timeout", i), 64'(r_timeout), 64'(vecs[i].exp_to));
            check($sformatf("v%0d_err_range", i), 64'(err_range), 64'(vecs[i].exp_rng));
            check($sformatf("v%0d_operands", i), 64'({cp_T_in, cp_dT_in}),
                  64'({vecs[i].t, vecs[i].dt}));
            check($sformatf("v%0d_busy_fell", i), 64'(busy), 64'd0);
            check($sformatf("v%0d_one_start", i), 64'(start_cnt - s0), 64'd1);
            pop();
            check($sformatf("v%0d_popped", i), 64'(r_valid), 64'd0);
        end

        // Back-pressure: four results fill the FIFO, the fifth waits for a pop.
        r_ready = 1'b0; cop_lat = 2; cop_silent = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cop_g = 8'(10 * k + 1);
            send(8'(k), 8'(k), 1'b0, ok);
            wait_idle();
        end
        cop_g = 8'd41;
        s_T = 8'd4; s_dT = 8'd4; s_init = 1'b0; s_valid = 1'b1;
        tick();
        tick();
        check("full_s_ready_low", 64'(s_ready), 64'd0);
        check("full_not_accepted", 64'(busy), 64'd0);
        check("full_head", 64'({r_valid, r_G}), 64'({1'b1, 8'd1}));
        pop();
        send(8'd4, 8'd4, 1'b0, ok);
        wait_idle();

        // Spurious strobe in IDLE with a full FIFO: flag only, no extra entry.
        check("spurious_clear", 64'(err_spurious), 64'd0);
        force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        check("spurious_set", 64'(err_spurious), 64'd1);
        check("spurious_no_busy", 64'(busy), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d", k), 64'({r_valid, r_G, r_lat}),
                  64'({1'b1, 8'(10 * k + 1), 6'd2}));
            pop();
        end
        check("drain_empty", 64'(r_valid), 64'd0);

        // Randomized run with random consumer back-pressure.
        mon_en = 1'b1; rnd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rt = 8'($urandom); rdt = 8'($urandom); rg = 8'($urandom_range(0, 255));
            rlat = $urandom_range(1, 34);
            rsil = ($urandom_range(0, 7) == 0);
            rini = $urandom_range(0, 1);
            cop_lat = rlat; cop_g = rg; cop_silent = rsil;
            send(rt, rdt, rini, ok);
            if (ok) exp_q.push_back(model(rg, rlat, rsil));
            wait_idle();
        end
        rnd_ready = 1'b0;
        r_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
        check("rand_all_scored", 64'(exp_q.size()), 64'd0);
        tick();
        r_ready = 1'b0;
        check("rand_fifo_empty", 64'(r_valid), 64'd0);
        mon_en = 1'b0;

        // Reset in the middle of WAIT drops the sample.
        cop_lat = 20; cop_g = 8'd33; cop_silent = 1'b0;
        send(8'd9, 8'd9, 1'b0, ok);
        repeat (5) tick();
        check("mid_wait_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1 check("async_reset_outputs", out_vec(), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("ready_low_after_release", 64'(s_ready), 64'd0);
        tick();
        check("ready_after_release_edge", 64'(s_ready), 64'd1);
        repeat (30) tick();
        check("dropped_no_result", 64'({r_valid, busy, err_spurious}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
